// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared word/entry types and store-buffer sizing.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t adr;
        word_t data;
    } sb_entry_t;

    localparam int SB_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : sb_fwd_match
// Brief    : Combinational youngest-match search over the store buffer.
// Revision : 1.0
// ============================================================================
module sb_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int WW    = 30,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [WW-1:0]    entry_wadr_i [DEPTH],
    input  logic [DEPTH-1:0] valid_i,
    input  logic [PTR_W-1:0] rd_ptr_i,
    input  logic [WW-1:0]    lookup_wadr_i,
    output logic             hit_o,
    output logic [PTR_W-1:0] idx_o
);

    logic [PTR_W-1:0] w_slot;

    // Walk from oldest (rd_ptr) to youngest; a later match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        w_slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = rd_ptr_i + PTR_W'(k);
            if (valid_i[w_slot] && (entry_wadr_i[w_slot] == lookup_wadr_i)) begin
                hit_o = 1'b1;
                idx_o = w_slot;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Posted-write FIFO between MEM stage and data memory with
//            store-to-load forwarding and full-stall.
// Revision : 1.0
// ============================================================================
module store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] writedata,
    input  logic          memread,
    input  logic [AW-1:0] rd_adr,
    output logic          stall,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;

    logic [AW-1:0]      adr_q  [DEPTH];
    logic [DW-1:0]      data_q [DEPTH];
    logic [AW-3:0]      w_entry_wadr [DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_inc_hit;
    logic               w_buf_hit;
    logic [c_PTR_W-1:0] w_buf_idx;
    logic               w_unused;

    assign w_full  = (count_q == c_FULL_CNT);
    assign w_empty = (count_q == '0);
    // A drain in the same cycle never frees room for a store presented while full.
    assign w_push  = memwrite & ~w_full;
    assign w_pop   = ~w_empty & mem_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        count_d  = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        if (w_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + c_PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (wr_ptr_q == c_PTR_W'(g))) begin
                    adr_q[g]  <= adr;
                    data_q[g] <= writedata;
                end
            end
            assign w_entry_wadr[g] = adr_q[g][AW-1:2];
        end
    endgenerate

    assign stall     = w_full;
    assign mem_we    = ~w_empty;
    assign mem_adr   = w_empty ? '0 : adr_q[rd_ptr_q];
    assign mem_wdata = w_empty ? '0 : data_q[rd_ptr_q];

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .WW    (AW - 2),
        .PTR_W (c_PTR_W)
    ) u_fwd_match (
        .entry_wadr_i  (w_entry_wadr),
        .valid_i       (valid_q),
        .rd_ptr_i      (rd_ptr_q),
        .lookup_wadr_i (rd_adr[AW-1:2]),
        .hit_o         (w_buf_hit),
        .idx_o         (w_buf_idx)
    );

    assign w_inc_hit = memread & w_push & (adr[AW-1:2] == rd_adr[AW-1:2]);

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (w_inc_hit) begin
            fwd_hit  = 1'b1;
            fwd_data = writedata;
        end else if (memread && w_buf_hit) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[w_buf_idx];
        end
    end

    // Matching is on word addresses; the byte offset of a load is irrelevant.
    assign w_unused = ^rd_adr[1:0];

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Self-checking bench for store_buffer (vector table + drain scoreboard).
// Revision : 1.0
// ============================================================================
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] writedata = '0;
    logic        memread = 1'b0;
    logic [31:0] rd_adr = '0;
    logic        mem_ready = 1'b0;
    logic        stall;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .memread   (memread),
        .rd_adr    (rd_adr),
        .stall     (stall),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference occupancy model and expected drain order.
    logic [63:0] exp_q[$];
    int          m_count = 0;
    logic        m_accept;
    logic        m_drain;
    logic [63:0] m_head;

    always @(negedge clk) begin
        if (reset) begin
            m_count = 0;
            exp_q.delete();
        end else begin
            check("stall", 32'(stall), 32'(m_count == 4));
            check("mem_we", 32'(mem_we), 32'(m_count > 0));
            m_drain  = (m_count > 0) && mem_ready;
            m_accept = memwrite && (m_count < 4);
            if (m_drain) begin
                m_head = exp_q.pop_front();
                check("drain_adr", mem_adr, m_head[63:32]);
                check("drain_data", mem_wdata, m_head[31:0]);
            end
            if (m_accept) exp_q.push_back({adr, writedata});
            m_count = m_count + int'(m_accept) - int'(m_drain);
        end
    end

    typedef struct {
        logic        mw;
        logic [31:0] a;
        logic [31:0] d;
        logic        mr;
        logic [31:0] ra;
        logic        rdy;
        logic        e_stall;
        logic        e_hit;
        logic [31:0] e_fdata;
        logic        e_we;
        logic [31:0] e_madr;
        logic [31:0] e_mwd;
    } vec_t;

    vec_t vt[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d,
                         input logic mr, input logic [31:0] ra, input logic rdy);
        memwrite  = mw;
        adr       = a;
        writedata = d;
        memread   = mr;
        rd_adr    = ra;
        mem_ready = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        //          mw  a    d   mr  ra   rdy stl hit fd  we madr mwd
        vt[0]  = '{0,  0,   0,  0,  0,   0,  0,  0,  0,  0, 0,   0};
        vt[1]  = '{1,  84,  7,  1,  86,  0,  0,  1,  7,  0, 0,   0};
        vt[2]  = '{1,  84,  9,  1,  84,  0,  0,  1,  9,  1, 84,  7};
        vt[3]  = '{0,  0,   0,  1,  86,  0,  0,  1,  9,  1, 84,  7};
        vt[4]  = '{1,  84,  11, 1,  84,  0,  0,  1,  11, 1, 84,  7};
        vt[5]  = '{0,  0,   0,  1,  88,  0,  0,  0,  0,  1, 84,  7};
        vt[6]  = '{0,  0,   0,  0,  84,  0,  0,  0,  0,  1, 84,  7};
        vt[7]  = '{1,  100, 5,  1,  100, 0,  0,  1,  5,  1, 84,  7};
        vt[8]  = '{1,  104, 6,  1,  104, 0,  1,  0,  0,  1, 84,  7};
        vt[9]  = '{1,  104, 6,  1,  84,  1,  1,  1,  11, 1, 84,  7};
        vt[10] = '{1,  104, 6,  1,  104, 0,  0,  1,  6,  1, 84,  9};
        vt[11] = '{0,  0,   0,  1,  100, 1,  1,  1,  5,  1, 84,  9};
        vt[12] = '{0,  0,   0,  1,  84,  1,  0,  1,  11, 1, 84,  11};
        vt[13] = '{0,  0,   0,  1,  84,  1,  0,  0,  0,  1, 100, 5};
        vt[14] = '{0,  0,   0,  1,  104, 1,  0,  1,  6,  1, 104, 6};
        vt[15] = '{0,  0,   0,  0,  0,   0,  0,  0,  0,  0, 0,   0};

        // Reset held 22 ns, outputs quiet.
        #8;
        check("rst_stall", 32'(stall), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_fwd_hit", 32'(fwd_hit), 0);
        check("rst_fwd_data", fwd_data, 0);
        check("rst_mem_adr", mem_adr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        #14;
        reset = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 84, 0);
            #3;
            check("idle_fwd_hit", 32'(fwd_hit), 0);
            check("idle_stall", 32'(stall), 0);
            check("idle_mem_we", 32'(mem_we), 0);
            step();
        end

        // Single store, drained the following cycle.
        drive(1, 84, 7, 0, 0, 1);
        #3;
        check("t2_we_before", 32'(mem_we), 0);
        step();
        drive(0, 0, 0, 0, 0, 1);
        #3;
        check("t2_we", 32'(mem_we), 1);
        check("t2_adr", mem_adr, 84);
        check("t2_wdata", mem_wdata, 7);
        step();
        #3;
        check("t2_we_after", 32'(mem_we), 0);
        step();

        // Forwarding priority and full-buffer behaviour.
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].mw, vt[i].a, vt[i].d, vt[i].mr, vt[i].ra, vt[i].rdy);
            #3;
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
            check($sformatf("v%0d_hit", i), 32'(fwd_hit), 32'(vt[i].e_hit));
            check($sformatf("v%0d_fdata", i), fwd_data, vt[i].e_fdata);
            check($sformatf("v%0d_we", i), 32'(mem_we), 32'(vt[i].e_we));
            check($sformatf("v%0d_madr", i), mem_adr, vt[i].e_madr);
            check($sformatf("v%0d_mwd", i), mem_wdata, vt[i].e_mwd);
            step();
        end

        // Fill, hold a fifth store, then drain all in order.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(80 + 4 * i), 32'(i + 1), 0, 0, 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 96, 5, 0, 0, 0);
            #3;
            check("t3_stall_held", 32'(stall), 1);
            step();
        end
        begin : t3_release
            logic accepted;
            accepted = 1'b0;
            for (int i = 0; i < 10 && !accepted; i++) begin
                drive(1, 96, 5, 0, 0, 1);
                #3;
                if (!stall) accepted = 1'b1;
                step();
            end
            check("t3_fifth_accepted", 32'(accepted), 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            #3;
            if (!mem_we && exp_q.size() == 0) break;
            step();
        end
        check("t3_drain_done", 32'(!mem_we && exp_q.size() == 0), 1);
        step();

        // Asynchronous reset with pending stores.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(160 + 4 * i), 32'(32'h50 + i), 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_we_async", 32'(mem_we), 0);
        check("t6_stall_async", 32'(stall), 0);
        check("t6_adr_async", mem_adr, 0);
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            check("t6_no_write", 32'(mem_we), 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
